multicycle_ctrl_fsm: RTL and testbench

Control sequencer for the multi-cycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the shared-datapath mux selects, the ALU op class and the write strobes. It also handshakes with a single unified instruction/data memory port that may insert wait states.

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_fsm_if.sv | 35 +++
 rtl/multicycle_ctrl_fsm_imm_dec.sv | 21 ++
 rtl/multicycle_ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: state codes,
// opcodes and the datapath select values driven by the controller.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_LUI      = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic {ADR_PC = 1'b0, ADR_RESULT = 1'b1} adr_src_e;

  typedef enum logic [1:0] {
    A_PC = 2'b00, A_OLD_PC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11
  } alu_a_e;

  typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} alu_b_e;

  typedef enum logic [1:0] {
    RES_ALU_OUT = 2'b00, RES_READ_DATA = 2'b01, RES_ALU = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100
  } imm_src_e;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath/memory signal bundle. The controller takes the
// master side; the datapath and memory port take the slave side.
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic       mem_ready;
  logic       branch_taken;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [2:0] imm_src;
  logic       illegal_instr;
  logic       instr_retire;
  logic [3:0] state;

  modport master (
    input  op, mem_ready, branch_taken,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           illegal_instr, instr_retire, state
  );

  modport slave (
    output op, mem_ready, branch_taken,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           illegal_instr, instr_retire, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_imm_dec.sv
// Immediate-format decoder: picks the immediate layout from the opcode alone,
// independent of the sequencer state.
module imm_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output imm_src_e   imm_src
);

  always_comb begin
    unique case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_src = IMM_I;
      OP_STORE:                 imm_src = IMM_S;
      OP_BRANCH:                imm_src = IMM_B;
      OP_AUIPC, OP_LUI:         imm_src = IMM_U;
      OP_JAL:                   imm_src = IMM_J;
      default:                  imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: state register, next-state logic and
// per-state decode of datapath selects, ALU op class and write strobes.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_ctrl_fsm_if.master bus
);

  state_e      state_q, state_d;
  imm_src_e    imm_src;
  logic        mem_req, mem_write, ir_write, pc_write, reg_write;
  logic        illegal_instr, instr_retire;
  adr_src_e    adr_src;
  alu_a_e      alu_src_a;
  alu_b_e      alu_src_b;
  alu_op_e     alu_op;
  result_src_e result_src;

  imm_dec u_imm_dec (
    .op      (bus.op),
    .imm_src (imm_src)
  );

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_AUIPC:          state_d = S_ALUWB;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
      S_JALR_ADR: state_d = S_JAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = ADR_PC;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    alu_op        = ALU_ADD;
    result_src    = RES_ALU_OUT;
    illegal_instr = 1'b0;
    instr_retire  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = A_OLD_PC;
        alu_src_b = B_IMM;
      end
      S_MEMADR, S_JALR_ADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = ADR_RESULT;
      end
      S_MEMWB: begin
        result_src   = RES_READ_DATA;
        reg_write    = 1'b1;
        instr_retire = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req      = 1'b1;
        mem_write    = 1'b1;
        adr_src      = ADR_RESULT;
        instr_retire = bus.mem_ready;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        instr_retire = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = A_RS1;
        alu_op       = ALU_SUB;
        pc_write     = bus.branch_taken;
        instr_retire = 1'b1;
      end
      S_JAL: begin
        alu_src_a = A_OLD_PC;
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
      end
      S_ILLEGAL: illegal_instr = 1'b1;
      default: ;
    endcase
    // state_q is already FETCH during reset, so only the strobes need forcing.
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      instr_retire  = 1'b0;
    end
  end

  assign bus.mem_req       = mem_req;
  assign bus.mem_write     = mem_write;
  assign bus.adr_src       = adr_src;
  assign bus.ir_write      = ir_write;
  assign bus.pc_write      = pc_write;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.result_src    = result_src;
  assign bus.imm_src       = imm_src;
  assign bus.illegal_instr = illegal_instr;
  assign bus.instr_retire  = instr_retire;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: each instruction is expanded by a reference model into
// its expected per-cycle trace, and the controller outputs are compared every cycle.
module tb_multicycle_ctrl_fsm;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Flag byte order: req, wr, adr, ir_write, pc_write, reg_write, illegal, retire.
  typedef struct {
    logic [3:0] st;
    logic       rdy;
    logic [7:0] fl;
    logic [1:0] rs, a, b, aop;
  } step_t;

  step_t trace[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] obs_vec();
    return {bus.state, bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write,
            bus.pc_write, bus.reg_write, bus.illegal_instr, bus.instr_retire,
            bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.imm_src};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'b001;
      OP_BRANCH:        return 3'b010;
      OP_AUIPC, OP_LUI: return 3'b011;
      OP_JAL:           return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  // Cycles per instruction with no wait states.
  function automatic int cpi(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_JALR:              return 5;
      OP_STORE, OP_R, OP_IMM,
      OP_JAL, OP_LUI:                return 4;
      default:                       return 3;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic void push(input int st, input logic rdy, input logic [7:0] fl,
                               input logic [1:0] rs, a, b, aop);
    step_t s;
    s.st = 4'(st); s.rdy = rdy; s.fl = fl; s.rs = rs; s.a = a; s.b = b; s.aop = aop;
    trace.push_back(s);
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic void push_aluwb();
    push(8, rnd(), 8'b0000_0101, 2'b00, 2'b00, 2'b00, 2'b00);
  endfunction

  function automatic void push_jal();
    push(10, rnd(), 8'b0000_1000, 2'b00, 2'b01, 2'b10, 2'b00);
  endfunction

  // Expected trace: fetch (with waits), decode, then the opcode's own path.
  function automatic void build(input logic [6:0] op, input int fw, input int mw, input logic bt);
    trace.delete();
    for (int i = 0; i < fw; i++) push(0, 1'b0, 8'b1000_0000, 2'b10, 2'b00, 2'b10, 2'b00);
    push(0, 1'b1, 8'b1001_1000, 2'b10, 2'b00, 2'b10, 2'b00);
    push(1, rnd(), 8'b0, 2'b00, 2'b01, 2'b01, 2'b00);
    case (op)
      OP_LOAD: begin
        push(2, rnd(), 8'b0, 2'b00, 2'b10, 2'b01, 2'b00);
        for (int i = 0; i < mw; i++) push(3, 1'b0, 8'b1010_0000, 2'b00, 2'b00, 2'b00, 2'b00);
        push(3, 1'b1, 8'b1010_0000, 2'b00, 2'b00, 2'b00, 2'b00);
        push(4, rnd(), 8'b0000_0101, 2'b01, 2'b00, 2'b00, 2'b00);
      end
      OP_STORE: begin
        push(2, rnd(), 8'b0, 2'b00, 2'b10, 2'b01, 2'b00);
        for (int i = 0; i < mw; i++) push(5, 1'b0, 8'b1110_0000, 2'b00, 2'b00, 2'b00, 2'b00);
        push(5, 1'b1, 8'b1110_0001, 2'b00, 2'b00, 2'b00, 2'b00);
      end
      OP_R:      begin push(6, rnd(), 8'b0, 2'b00, 2'b10, 2'b00, 2'b10); push_aluwb(); end
      OP_IMM:    begin push(7, rnd(), 8'b0, 2'b00, 2'b10, 2'b01, 2'b10); push_aluwb(); end
      OP_AUIPC:  push_aluwb();
      OP_LUI:    begin push(12, rnd(), 8'b0, 2'b00, 2'b11, 2'b01, 2'b00); push_aluwb(); end
      OP_JAL:    begin push_jal(); push_aluwb(); end
      OP_JALR: begin
        push(11, rnd(), 8'b0, 2'b00, 2'b10, 2'b01, 2'b00);
        push_jal();
        push_aluwb();
      end
      OP_BRANCH: push(9, rnd(), {4'b0000, bt, 3'b001}, 2'b00, 2'b10, 2'b00, 2'b01);
      default:   push(13, rnd(), 8'b0000_0010, 2'b00, 2'b00, 2'b00, 2'b00);
    endcase
  endfunction

  task automatic run_instr(input string name, input logic [6:0] op, input int fw,
                           input int mw, input logic bt);
    int done_at = 0;
    int rets    = 0;
    int waits;
    build(op, fw, mw, bt);
    waits = fw + (((op == OP_LOAD) || (op == OP_STORE)) ? mw : 0);
    foreach (trace[i]) begin
      @(negedge clk);
      bus.op           = op;
      bus.mem_ready    = trace[i].rdy;
      bus.branch_taken = bt;
      #1;
      check($sformatf("%s op=%b cyc%0d", name, op, i), 32'(obs_vec()),
            32'({trace[i].st, trace[i].fl, trace[i].rs, trace[i].a, trace[i].b,
                 trace[i].aop, exp_imm(op)}));
      if ((bus.instr_retire === 1'b1 || bus.illegal_instr === 1'b1) && done_at == 0)
        done_at = i + 1;
      if (bus.instr_retire === 1'b1) rets++;
    end
    check($sformatf("%s op=%b cycles", name, op), 32'(done_at), 32'(cpi(op) + waits));
    check($sformatf("%s op=%b retires", name, op), 32'(rets), 32'(is_legal(op) ? 1 : 0));
  endtask

  logic [6:0] ops [10];
  logic [6:0] rop;

  initial begin
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_IMM, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, 7'b1111111};

    // Reset with ready and taken asserted: strobes must stay low, selects at FETCH values.
    rst_n = 1'b0;
    bus.op = OP_STORE;
    bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 32'(obs_vec()),
             32'({4'd0, 8'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b001}));
    @(negedge clk);
    bus.op = OP_JAL;
    #1 check("reset_imm_follows_op", 32'(obs_vec()),
             32'({4'd0, 8'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b100}));

    // Release with memory stalled: one stall cycle here, two more in the first fetch.
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.op = OP_LOAD;
    rst_n = 1'b1;
    #1 check("release_fetch_stall", 32'(obs_vec()),
             32'({4'd0, 8'b1000_0000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000}));
    run_instr("reset_stall_load", OP_LOAD, 2, 0, 1'b0);

    // Directed cases.
    run_instr("load_2wait", OP_LOAD, 0, 2, 1'b0);
    run_instr("store_1wait", OP_STORE, 0, 1, 1'b0);
    run_instr("branch_taken", OP_BRANCH, 0, 0, 1'b1);
    run_instr("branch_not_taken", OP_BRANCH, 0, 0, 1'b0);
    run_instr("jalr", OP_JALR, 0, 0, 1'b0);
    run_instr("illegal_ff", 7'b1111111, 0, 0, 1'b0);
    run_instr("auipc", OP_AUIPC, 1, 0, 1'b0);
    run_instr("lui", OP_LUI, 0, 0, 1'b0);

    // Random instruction mix with random wait states.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) rop = 7'($urandom);
      else rop = ops[$urandom_range(0, 9)];
      run_instr("random", rop, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
    end

    // Reset asserted while a store is waiting on memory.
    @(negedge clk); bus.op = OP_STORE; bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.mem_ready = 1'b0;
    #1 check("store_wait_before_reset", 32'({bus.state, bus.mem_write}), 32'({4'd5, 1'b1}));
    rst_n = 1'b0;
    #1 check("reset_mid_memwrite", 32'(obs_vec()),
             32'({4'd0, 8'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b001}));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("after_reset_r", OP_R, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
